// File: rtl/mem_bus_master.sv
// Single-request bus initiator for mem_space: valid/ready request in, one response pulse out.
// Drives MAB_in/MDB_in/MW/BW, rejects misaligned word accesses, captures MDB_out for reads.
module mem_bus_master #(
    parameter int unsigned READ_LAT  = 1,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_bw,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] MAB_in,
    output logic [15:0] MDB_in,
    output logic        MW,
    output logic        BW,
    input  logic [15:0] MDB_out
);

    localparam logic [1:0] LatInit = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StReadWait, StResp} state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [15:0] rsp_rdata_q;
    logic [15:0] mab_q;
    logic [15:0] mdb_q;
    logic        mw_q;
    logic        bw_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            mab_q       <= IDLE_ADDR;
            mdb_q       <= 16'h0000;
            mw_q        <= 1'b0;
            bw_q        <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            mw_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (!req_bw && req_addr[0]) begin
                            // Misaligned word: answer immediately, bus pins untouched.
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 16'h0000;
                        end else begin
                            mab_q <= req_addr;
                            bw_q  <= req_bw;
                            if (req_we) begin
                                state_q <= StWrite;
                                mw_q    <= 1'b1;
                                mdb_q   <= req_bw ? {8'h00, req_wdata[7:0]} : req_wdata;
                            end else begin
                                state_q <= StReadWait;
                                cnt_q   <= LatInit;
                            end
                        end
                    end
                end
                StWrite: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 16'h0000;
                end
                StReadWait: begin
                    if (cnt_q == 2'd0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= bw_q ? {8'h00, MDB_out[7:0]} : MDB_out;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign MAB_in    = mab_q;
    assign MDB_in    = mdb_q;
    assign MW        = mw_q;
    assign BW        = bw_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: instance a (READ_LAT=1) on a byte-array memory,
// instance b (READ_LAT=3, IDLE_ADDR=FFFE) on a pipelined read-only pattern memory.
module tb_mem_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance a
    logic        rst_n, req_valid, req_ready, req_we, req_bw;
    logic [15:0] req_addr, req_wdata, rsp_rdata, mab, mdb_in, mdb_out;
    logic        rsp_valid, rsp_err, mw, bw;

    // Instance b
    logic        rst_n_b, req_valid_b, req_ready_b, req_we_b, req_bw_b;
    logic [15:0] req_addr_b, req_wdata_b, rsp_rdata_b, mab_b, mdb_in_b, mdb_out_b;
    logic        rsp_valid_b, rsp_err_b, mw_b, bw_b;

    mem_bus_master dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_bw(req_bw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MAB_in(mab), .MDB_in(mdb_in), .MW(mw), .BW(bw), .MDB_out(mdb_out)
    );

    mem_bus_master #(.READ_LAT(3), .IDLE_ADDR(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we_b), .req_bw(req_bw_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .MAB_in(mab_b), .MDB_in(mdb_in_b), .MW(mw_b), .BW(bw_b), .MDB_out(mdb_out_b)
    );

    // Memory for a: little-endian bytes, zero-latency read, junk in the upper byte lane.
    logic [7:0] mem_a [0:65535];
    always @(posedge clk) begin
        if (mw) begin
            if (bw) begin
                mem_a[mab] <= mdb_in[7:0];
            end else begin
                mem_a[{mab[15:1], 1'b0}] <= mdb_in[7:0];
                mem_a[{mab[15:1], 1'b1}] <= mdb_in[15:8];
            end
        end
    end
    assign mdb_out = bw ? {8'hA5, mem_a[mab]}
                        : {mem_a[{mab[15:1], 1'b1}], mem_a[{mab[15:1], 1'b0}]};

    // Memory for b: word(a) = {a[15:1],0} ^ 5634, two register stages of delay.
    logic [15:0] word_b, comb_b, d1_b, d2_b;
    assign word_b = {mab_b[15:1], 1'b0} ^ 16'h5634;
    assign comb_b = bw_b ? {8'hA5, (mab_b[0] ? word_b[15:8] : word_b[7:0])} : word_b;
    always @(posedge clk) begin
        d1_b <= comb_b;
        d2_b <= d1_b;
    end
    assign mdb_out_b = d2_b;

    int mw_pulses = 0;
    int rsp_pulses = 0;
    always @(posedge clk) begin
        if (mw) mw_pulses <= mw_pulses + 1;
        if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request on instance a, starting from IDLE at #1 after an edge.
    task automatic xact(input string tag, input logic we, input logic bwi,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [15:0] exp_rdata);
        int          cyc;
        int          mw_cnt;
        int          mw_cyc;
        logic [15:0] mab0;
        logic [15:0] mdb_seen;
        mab0     = mab;
        mw_cnt   = 0;
        mw_cyc   = 0;
        mdb_seen = 16'h0000;
        check({tag, "_rdy"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_bw    = bwi;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 12) begin
            check({tag, "_busy"}, req_ready, 0);
            check({tag, "_mab"}, mab, addr);
            check({tag, "_bw"}, bw, bwi);
            if (mw) begin
                mw_cnt++;
                mw_cyc   = cyc;
                mdb_seen = mdb_in;
            end
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_mw_rsp"}, mw, 0);
        check({tag, "_mw_cnt"}, mw_cnt, (we && !exp_err) ? 1 : 0);
        if (mw_cnt == 1) begin
            check({tag, "_mw_cyc"}, mw_cyc, 1);
            check({tag, "_mdb"}, mdb_seen, bwi ? {8'h00, wdata[7:0]} : wdata);
        end
        if (exp_err) check({tag, "_mab_hold"}, mab, mab0);
        tick();
        check({tag, "_pulse"}, rsp_valid, 0);
        check({tag, "_idle"}, req_ready, 1);
    endtask

    // Read on instance b (READ_LAT=3): response expected in cycle 4.
    task automatic read_b(input string tag, input logic bwi, input logic [15:0] addr,
                          input logic [15:0] exp_rdata);
        int cyc;
        check({tag, "_rdy"}, req_ready_b, 1);
        req_valid_b = 1'b1;
        req_we_b    = 1'b0;
        req_bw_b    = bwi;
        req_addr_b  = addr;
        tick();
        req_valid_b = 1'b0;
        cyc = 1;
        while (!rsp_valid_b && cyc < 12) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, 4);
        check({tag, "_rdata"}, rsp_rdata_b, exp_rdata);
        check({tag, "_err"}, rsp_err_b, 0);
        tick();
    endtask

    initial begin
        int mw0;
        int rs0;
        int seen;
        rst_n = 1'b0;  req_valid = 1'b0;  req_we = 1'b0;  req_bw = 1'b0;
        req_addr = 16'h0;  req_wdata = 16'h0;
        rst_n_b = 1'b0;  req_valid_b = 1'b0;  req_we_b = 1'b0;  req_bw_b = 1'b0;
        req_addr_b = 16'h0;  req_wdata_b = 16'h0;
        repeat (3) tick();

        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 16'h0000);
        check("rst_mw", mw, 0);
        check("rst_bw", bw, 0);
        check("rst_mdb", mdb_in, 16'h0000);
        check("rst_mab", mab, 16'h0000);
        check("rst_b_mab", mab_b, 16'hFFFE);
        check("rst_b_mw", mw_b, 0);
        check("rst_b_bw", bw_b, 0);
        check("rst_b_mdb", mdb_in_b, 16'h0000);
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        tick();

        xact("t1_wr", 1'b1, 1'b0, 16'h0200, 16'hBEEF, 2, 1'b0, 16'h0000);
        xact("t1_rd", 1'b0, 1'b0, 16'h0200, 16'h0000, 2, 1'b0, 16'hBEEF);

        xact("t2_bwr", 1'b1, 1'b1, 16'h0201, 16'hAB12, 2, 1'b0, 16'h0000);
        xact("t2_wrd", 1'b0, 1'b0, 16'h0200, 16'h0000, 2, 1'b0, 16'h12EF);
        xact("t2_brd", 1'b0, 1'b1, 16'h0201, 16'h0000, 2, 1'b0, 16'h0012);

        xact("t3_misr", 1'b0, 1'b0, 16'h0203, 16'h0000, 1, 1'b1, 16'h0000);
        xact("t3_misw", 1'b1, 1'b0, 16'h0205, 16'h7777, 1, 1'b1, 16'h0000);

        mw0 = mw_pulses;
        rs0 = rsp_pulses;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_bw    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr  = 16'h0210 + 16'(2 * i);
            req_wdata = 16'(16'h1111 * (i + 1));
            check("t4_rdy", req_ready, 1);
            tick();
            check("t4_busy1", req_ready, 0);
            check("t4_mw", mw, 1);
            tick();
            check("t4_rsp", rsp_valid, 1);
            check("t4_busy2", req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        check("t4_mw_pulses", mw_pulses - mw0, 3);
        check("t4_rsp_pulses", rsp_pulses - rs0, 3);
        xact("t4_rd1", 1'b0, 1'b0, 16'h0212, 16'h0000, 2, 1'b0, 16'h2222);
        xact("t4_rd2", 1'b0, 1'b0, 16'h0214, 16'h0000, 2, 1'b0, 16'h3333);

        check("t5_rdy", req_ready_b, 1);
        req_valid_b = 1'b1;
        req_we_b    = 1'b0;
        req_bw_b    = 1'b0;
        req_addr_b  = 16'h0300;
        tick();
        req_valid_b = 1'b0;
        check("t5_mab", mab_b, 16'h0300);
        check("t5_c1_rsp", rsp_valid_b, 0);
        tick();
        check("t5_c2_rsp", rsp_valid_b, 0);
        check("t5_c2_busy", req_ready_b, 0);
        rst_n_b = 1'b0;
        tick();
        rst_n_b = 1'b1;
        check("t5_rst_rsp", rsp_valid_b, 0);
        check("t5_rst_rdy", req_ready_b, 1);
        check("t5_rst_mab", mab_b, 16'hFFFE);
        check("t5_rst_mw", mw_b, 0);
        seen = 0;
        repeat (5) begin
            if (rsp_valid_b) seen++;
            tick();
        end
        check("t5_no_rsp", seen, 0);
        read_b("t5_rdw", 1'b0, 16'h0300, 16'h5534);
        read_b("t5_rdb", 1'b1, 16'h0301, 16'h0055);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
